// File: rtl/slip_timer_pkg.sv
// Shared register map, control bit positions and control register layout for the interval timer.
package slip_timer_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] TMR_LO  = 2'd0;
    localparam logic [ADDR_W-1:0] TMR_HI  = 2'd1;
    localparam logic [ADDR_W-1:0] TMR_CTL = 2'd2;
    localparam logic [ADDR_W-1:0] TMR_PRE = 2'd3;

    localparam int unsigned CTL_RUN = 0;
    localparam int unsigned CTL_PER = 1;
    localparam int unsigned CTL_IEN = 2;
    localparam int unsigned CTL_INT = 7;

    // Control register as seen on a read; reserved bits always read 0.
    typedef struct packed {
        logic       int_flag;
        logic [3:0] rsvd;
        logic       ien;
        logic       per;
        logic       run;
    } ctl_t;

endpackage

// File: rtl/ld_down_counter.sv
// Loadable down-counter built from per-bit load-or-hold cells with a ripple toggle-enable chain.
module ld_down_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_c_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH:0]   zchain;

    // Per-bit AO2A: load selects new data, otherwise hold or toggle when all lower bits are zero.
    always_comb begin
        zchain    = '0;
        cnt_d     = cnt_q;
        zchain[0] = 1'b1;
        for (int n = 0; n < int'(WIDTH); n++) begin
            cnt_d[n]    = (load_i & load_data_i[n]) |
                          (~load_i & (cnt_q[n] ^ (en_i & zchain[n])));
            zchain[n+1] = zchain[n] & ~cnt_q[n];
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o  = cnt_q;
    assign zero_c_o = zchain[WIDTH];

endmodule

// File: rtl/slip_interval_timer.sv
// Programmable interval timer: prescaler, down-counter, one-shot/periodic modes, IRQ handshake.
module slip_interval_timer
    import slip_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PRE_W = 8
) (
    input  logic              MasterClock,
    input  logic              RESETL,
    input  logic              CKEN,
    input  logic              WR,
    input  logic              RD,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              INT,
    input  logic              INTACK,
    output logic              TC
);

    localparam int unsigned HI_W = WIDTH - 8;

    logic [7:0]       reload_lo_q, reload_lo_d;
    logic [HI_W-1:0]  reload_hi_q, reload_hi_d;
    logic [PRE_W-1:0] pre_val_q, pre_val_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [HI_W-1:0]  shadow_q, shadow_d;
    logic             run_q, run_d;
    logic             per_q, per_d;
    logic             ien_q, ien_d;
    logic             int_q, int_d;
    logic             tc_q, tc_d;

    logic             wr_lo, wr_hi, wr_ctl, wr_pre;
    logic             tick;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_data;
    logic             cnt_en;
    logic [WIDTH-1:0] count;
    logic             cnt_zero;
    ctl_t             ctl_rd;

    ld_down_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk         (MasterClock),
        .rst_n       (RESETL),
        .load_i      (cnt_load),
        .load_data_i (cnt_load_data),
        .en_i        (cnt_en),
        .count_o     (count),
        .zero_c_o    (cnt_zero)
    );

    // Register decode, tick generation, counter control and next-state for all timer registers.
    always_comb begin
        wr_lo  = WR && (ADDR == TMR_LO);
        wr_hi  = WR && (ADDR == TMR_HI);
        wr_ctl = WR && (ADDR == TMR_CTL);
        wr_pre = WR && (ADDR == TMR_PRE);

        tick = CKEN && run_q && (pre_cnt_q == pre_val_q);

        // A high-byte write loads the count and overrides any tick in the same cycle.
        cnt_load      = wr_hi || (tick && cnt_zero && per_q);
        cnt_load_data = wr_hi ? {HI_W'(DIN), reload_lo_q} : {reload_hi_q, reload_lo_q};
        cnt_en        = tick && !cnt_zero && !wr_hi;
        tc_d          = tick && cnt_zero && !wr_hi;

        reload_lo_d = wr_lo  ? DIN : reload_lo_q;
        reload_hi_d = wr_hi  ? HI_W'(DIN) : reload_hi_q;
        pre_val_d   = wr_pre ? PRE_W'(DIN) : pre_val_q;

        pre_cnt_d = pre_cnt_q;
        if (wr_hi || wr_pre) begin
            pre_cnt_d = '0;
        end else if (CKEN && run_q) begin
            pre_cnt_d = (pre_cnt_q == pre_val_q) ? '0 : pre_cnt_q + PRE_W'(1);
        end

        run_d = run_q;
        per_d = per_q;
        ien_d = ien_q;
        if (wr_ctl) begin
            run_d = DIN[CTL_RUN];
            per_d = DIN[CTL_PER];
            ien_d = DIN[CTL_IEN];
        end else if (tc_d && !per_q) begin
            run_d = 1'b0;
        end

        // Set on the visible TC strobe dominates any clear in the same cycle.
        int_d = int_q;
        if (tc_q && ien_q) begin
            int_d = 1'b1;
        end else if (INTACK || wr_ctl) begin
            int_d = 1'b0;
        end

        shadow_d = (RD && (ADDR == TMR_LO)) ? count[WIDTH-1:8] : shadow_q;
    end

    // Timer register state.
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            reload_lo_q <= '0;
            reload_hi_q <= '0;
            pre_val_q   <= '0;
            pre_cnt_q   <= '0;
            shadow_q    <= '0;
            run_q       <= 1'b0;
            per_q       <= 1'b0;
            ien_q       <= 1'b0;
            int_q       <= 1'b0;
            tc_q        <= 1'b0;
        end else begin
            reload_lo_q <= reload_lo_d;
            reload_hi_q <= reload_hi_d;
            pre_val_q   <= pre_val_d;
            pre_cnt_q   <= pre_cnt_d;
            shadow_q    <= shadow_d;
            run_q       <= run_d;
            per_q       <= per_d;
            ien_q       <= ien_d;
            int_q       <= int_d;
            tc_q        <= tc_d;
        end
    end

    // Read mux; the high byte comes from the shadow captured by the last low-byte read.
    always_comb begin
        ctl_rd          = '0;
        ctl_rd.run      = run_q;
        ctl_rd.per      = per_q;
        ctl_rd.ien      = ien_q;
        ctl_rd.int_flag = int_q;
        case (ADDR)
            TMR_LO:  DOUT = count[7:0];
            TMR_HI:  DOUT = DATA_W'(shadow_q);
            TMR_CTL: DOUT = ctl_rd;
            default: DOUT = DATA_W'(pre_val_q);
        endcase
    end

    assign INT = int_q;
    assign TC  = tc_q;

endmodule

// File: doc/slip_interval_timer.md
Name: slip_interval_timer

Overview:
- Programmable down-counting interval timer for the Slipstream counter group.
- Built from a chain of loadable, enable-cascaded counter bits (load/hold/toggle per bit), with a prescaler, terminal-count detect, one-shot and periodic modes, and an interrupt request/acknowledge handshake.
- Sits downstream of the CPU bus decoder and upstream of the interrupt controller.
- Its counter chain is the consumer of the per-bit load and enable signals the counter cells take.

Parameters:
- WIDTH, 16, main counter width in bits (even, 8..16).
- PRE_W, 8, prescaler width in bits.

Ports:
- MasterClock  input  1  system clock; all state on its rising edge.
- RESETL  input  1  asynchronous, active-low reset.
- CKEN  input  1  timer clock-enable pulse, one MasterClock wide; only source of count ticks.
- WR  input  1  register write strobe, one cycle.
- RD  input  1  register read strobe, one cycle.
- ADDR  input  2  register select: 0 = count/reload low, 1 = count/reload high, 2 = control, 3 = prescale.
- DIN  input  8  write data.
- DOUT  output  8  read data, combinational from ADDR and the shadow registers.
- INT  output  1  interrupt request, level, active-high.
- INTACK  input  1  interrupt acknowledge pulse.
- TC  output  1  terminal-count strobe, one MasterClock wide.

Behaviour:
- Reset (RESETL low, asynchronous):
  - count, reload, prescale value and prescale counter all 0.
  - control = 0 (stopped, one-shot, interrupt disabled).
  - INT = 0, TC = 0, read shadow = 0.
- Control register bits:
  - b0 RUN.
  - b1 PERIODIC.
  - b2 IEN.
  - b3..7 reserved: read 0, writes ignored.
- Writes:
  - addr0 stages the reload low byte only; the count is unchanged.
  - addr1 sets the reload high byte. In the same edge it parallel-loads count = {high, staged low} and clears the prescale counter (the LD path).
  - addr3 sets the prescale value and clears the prescale counter.
  - addr2 writes control and clears INT.
- Tick generation:
  - A tick occurs on a CKEN cycle with RUN = 1 and prescale counter == prescale value; the prescale counter then clears.
  - Other CKEN cycles with RUN = 1 increment the prescale counter.
  - Effective divide ratio is prescale + 1.
  - With RUN = 0 the prescaler holds.
- Count on a tick:
  - count != 0: decrement by 1, as a ripple-enable chain where bit n toggles when bits 0..n-1 are all 0.
  - count == 0: TC pulses for exactly the next cycle.
    - PERIODIC = 1: count reloads from the reload register.
    - PERIODIC = 0: RUN clears and count stays 0.
  - Period is therefore (reload + 1) * (prescale + 1) CKEN pulses.
- Write addr1 and tick in the same cycle: the load wins; no decrement and no TC.
- Interrupt:
  - INT sets on the TC strobe when IEN = 1.
  - INT clears on INTACK or on a control write.
  - TC and INTACK in the same cycle: INT stays set (set wins).
  - INT holds until cleared; a second TC while INT is set is not counted.
- Reads:
  - RD to addr0 returns count[7:0] and captures count[WIDTH-1:8] into the shadow. This gives a coherent 16-bit read.
  - addr1 returns the shadow, not the live count.
  - addr2 returns the control register, with b7 = INT.
  - addr3 returns the prescale value.
  - Reads have no side effects other than the shadow capture.
- Reset mid-count: everything returns to reset values at once; a pending INT is lost.
- Latency: a load takes effect at the write edge. TC follows one cycle after the tick that sees count 0.

Decomposition:
- Shared package slip_timer_pkg holds:
  - address constants (TMR_LO, TMR_HI, TMR_CTL, TMR_PRE);
  - control bit indices (CTL_RUN, CTL_PER, CTL_IEN, CTL_INT);
  - typedef ctl_t for the control register.
- One sub-module, ld_down_counter: WIDTH-bit loadable down-counter.
  - Inputs: load, load data, tick enable.
  - Outputs: count value and zero flag.
  - Internally uses per-bit AO2A load-or-hold logic with toggle enable from the lower-bit zero chain.

Test Plan:
- Reset/defaults: assert RESETL low mid-run with INT = 1 -> INT = 0, TC = 0, all reads return 0x00 within the same cycle.
- One-shot: write pre = 0, lo = 0x03, hi = 0x00, ctl = 0x05, CKEN every cycle -> TC pulses once on the 4th tick; INT = 1; RUN reads back 0; count holds 0.
- Periodic with prescale: pre = 2, reload = 0x0001, ctl = 0x03, CKEN continuous -> TC every 6 CKEN pulses for 5 periods; INT stays 0 with IEN clear.
- Borrow ripple: load 0x0100, tick once -> read lo = 0xFF, hi = 0x00. Then change count between the lo and hi reads -> hi still returns the shadow 0x00.
- Handshake collision: with INT = 1, drive INTACK in the same cycle as a new TC -> INT remains 1. Next INTACK alone -> INT = 0.
- Load vs tick: write hi = 0x12 (lo staged 0x34) on a tick cycle -> count = 0x1234, no TC, prescale counter 0.
